// File: rtl/demux1_8_32bit_buf_if.sv
// rtl/demux1_8_32bit_buf_if.sv - producer/consumer bus bundle for the buffered 1:8 demux (optional DEMUX_BROADCAST_EN)
interface demux1_8_32bit_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic [2:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic [7:0]           out_valid;
    logic [8*WIDTH-1:0]   out_data;
    logic [7:0]           out_ack;
    logic [CNT_W-1:0]     acc_count;
`ifdef DEMUX_BROADCAST_EN
    logic                 in_bcast;

    modport master (
        output in_valid, in_sel, in_data, out_ack, in_bcast,
        input  in_ready, out_valid, out_data, acc_count
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ack, in_bcast,
        output in_ready, out_valid, out_data, acc_count
    );
`else
    modport master (
        output in_valid, in_sel, in_data, out_ack,
        input  in_ready, out_valid, out_data, acc_count
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ack,
        output in_ready, out_valid, out_data, acc_count
    );
`endif
endinterface

// File: rtl/demux1_8_32bit_buf.sv
// rtl/demux1_8_32bit_buf.sv - buffered 1:8 word distributor with per-lane valid/ack (optional DEMUX_BROADCAST_EN)
module demux1_8_32bit_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    demux1_8_32bit_buf_if.slave    bus
);

    logic [7:0][WIDTH-1:0] r_data;
    logic [7:0]            r_valid;
    logic [CNT_W-1:0]      r_count;

    logic [7:0]            w_lane_rdy;
    logic [7:0]            w_load;
    logic                  w_bcast;
    logic                  w_ready;
    logic                  w_accept;

    // A lane can take a word when empty or when its current word leaves this cycle
    always_comb begin
        w_lane_rdy = ~r_valid | bus.out_ack;
`ifdef DEMUX_BROADCAST_EN
        w_bcast    = bus.in_bcast;
`else
        w_bcast    = 1'b0;
`endif
        w_ready    = w_bcast ? (&w_lane_rdy) : w_lane_rdy[bus.in_sel];
        w_accept   = bus.in_valid & w_ready;
        w_load     = 8'h00;
        if (w_accept) begin
            w_load = w_bcast ? 8'hFF : (8'h01 << bus.in_sel);
        end
    end

    // Lane holding registers: a load wins over an ack, so capture+ack keeps the lane full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= bus.in_data;
                    r_valid[i] <= 1'b1;
                end else if (bus.out_ack[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Accepted-word counter; a broadcast counts as one word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.acc_count = r_count;

endmodule
